qei_velocity: RTL and testbench



---
 rtl/tanq_pkg.sv | 10 +
 rtl/qei_moving_avg.sv | 61 ++++++
 rtl/qei_velocity.sv | 128 ++++++++++++
 tb/tb_qei_velocity.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tanq_pkg.sv
// Shared constants and types for the QEI velocity path in the fast clock domain.
package tanq_pkg;

    localparam int FAST_FREQ     = 120_000_000;
    localparam int POS_WIDTH_DEF = 32;
    localparam int VEL_WIDTH_DEF = 16;

    typedef logic signed [VEL_WIDTH_DEF-1:0] vel_t;

endpackage

// File: rtl/qei_moving_avg.sv
// Power-of-two moving average over a ring buffer with a running sum; one-cycle latency.
module qei_moving_avg
    import tanq_pkg::*;
#(
    parameter int VEL_WIDTH = VEL_WIDTH_DEF,
    parameter int AVG_LOG2  = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [VEL_WIDTH-1:0] in_data,
    output logic signed [VEL_WIDTH-1:0] out_data,
    output logic                        out_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = VEL_WIDTH + AVG_LOG2;

    logic signed [VEL_WIDTH-1:0] buf_q [DEPTH];
    logic        [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic signed [SUM_W-1:0]     sum_q, sum_d;
    logic signed [SUM_W-1:0]     avg_full_s;

    // Next running sum replaces the oldest sample; shift floors toward -infinity.
    always_comb begin
        sum_d      = sum_q + SUM_W'(in_data) - SUM_W'(buf_q[wr_ptr_q]);
        avg_full_s = sum_d >>> AVG_LOG2;
        if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
            wr_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    // Ring buffer, sum and output registers; clear flushes history but holds the last average.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wr_ptr_q  <= '0;
            sum_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wr_ptr_q  <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                buf_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= wr_ptr_d;
                sum_q           <= sum_d;
                out_data        <= avg_full_s[VEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/qei_velocity.sv
// Periodic position sampler producing saturated per-period velocity and its moving average.
module qei_velocity
    import tanq_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 120_000,
    parameter int POS_WIDTH     = POS_WIDTH_DEF,
    parameter int VEL_WIDTH     = VEL_WIDTH_DEF,
    parameter int AVG_LOG2      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic        [POS_WIDTH-1:0] qei_position,
    output logic signed [VEL_WIDTH-1:0] velocity_raw,
    output logic signed [VEL_WIDTH-1:0] velocity_avg,
    output logic                        saturated,
    output logic                        valid
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic signed [POS_WIDTH-1:0] VEL_MAX_P =
        (POS_WIDTH'(1) << (VEL_WIDTH - 1)) - POS_WIDTH'(1);
    localparam logic signed [POS_WIDTH-1:0] VEL_MIN_P = ~VEL_MAX_P;

    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic                        primed_q, primed_d;
    logic        [POS_WIDTH-1:0] last_q, last_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [VEL_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                        s1_sat_q, s1_sat_d;
    logic signed [VEL_WIDTH-1:0] raw_q, raw_d;
    logic                        sat_q, sat_d;
    logic                        tick_s, fire_s;
    logic signed [POS_WIDTH-1:0] delta_s;
    logic signed [VEL_WIDTH-1:0] clip_s;
    logic                        clip_sat_s;

    // Modulo subtraction makes position wrap in either direction yield the small signed delta.
    always_comb begin
        tick_s  = enable && (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
        fire_s  = s1_valid_q && enable;
        delta_s = $signed(qei_position - last_q);
        if (delta_s > VEL_MAX_P) begin
            clip_s     = VEL_MAX_P[VEL_WIDTH-1:0];
            clip_sat_s = 1'b1;
        end else if (delta_s < VEL_MIN_P) begin
            clip_s     = VEL_MIN_P[VEL_WIDTH-1:0];
            clip_sat_s = 1'b1;
        end else begin
            clip_s     = delta_s[VEL_WIDTH-1:0];
            clip_sat_s = 1'b0;
        end
    end

    // Period counter, priming and stage-1/stage-2 next-state.
    always_comb begin
        cnt_d      = cnt_q;
        primed_d   = primed_q;
        last_d     = last_q;
        s1_valid_d = tick_s && primed_q;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        raw_d      = raw_q;
        sat_d      = sat_q;
        if (!enable) begin
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (tick_s) begin
            cnt_d    = '0;
            primed_d = 1'b1;
            last_d   = qei_position;
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
        end
        if (tick_s && primed_q) begin
            s1_data_d = clip_s;
            s1_sat_d  = clip_sat_s;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (fire_s) begin
            raw_d = s1_data_q;
            sat_d = s1_sat_q;
        end else begin
            raw_d = raw_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            last_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sat_q   <= 1'b0;
            raw_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            last_q     <= last_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sat_q   <= s1_sat_d;
            raw_q      <= raw_d;
            sat_q      <= sat_d;
        end
    end

    qei_moving_avg #(
        .VEL_WIDTH (VEL_WIDTH),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg (
        .clock     (clock),
        .reset     (reset),
        .clear     (~enable),
        .in_valid  (fire_s),
        .in_data   (s1_data_q),
        .out_data  (velocity_avg),
        .out_valid (valid)
    );

    assign velocity_raw = raw_q;
    assign saturated    = sat_q;

endmodule

// File: tb/tb_qei_velocity.sv
// Directed self-checking bench for qei_velocity with an 8-cycle sample period.
module tb_qei_velocity;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic        [31:0] qei_position;
    logic signed [15:0] velocity_raw;
    logic signed [15:0] velocity_avg;
    logic               saturated;
    logic               valid;

    int checks = 0;
    int errors = 0;
    int avg_tab[5] = '{1, 2, 3, 5, 5};

    always #5 clock = ~clock;

    qei_velocity #(
        .SAMPLE_PERIOD (8),
        .POS_WIDTH     (32),
        .VEL_WIDTH     (16),
        .AVG_LOG2      (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .qei_position (qei_position),
        .velocity_raw (velocity_raw),
        .velocity_avg (velocity_avg),
        .saturated    (saturated),
        .valid        (valid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int raw, input int avg, input int sat);
        check({tag, " raw"}, int'(velocity_raw), raw);
        check({tag, " avg"}, int'(velocity_avg), avg);
        check({tag, " sat"}, int'(saturated), sat);
    endtask

    // Wait (bounded) for the next valid pulse, then check latency and outputs.
    task automatic expect_sample(input string tag, input int exp_cycles,
                                 input int raw, input int avg, input int sat);
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (valid) seen = 1'b1;
        end
        check({tag, " seen"}, int'(seen), 1);
        check({tag, " cycles"}, cyc, exp_cycles);
        check_outputs(tag, raw, avg, sat);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (valid) hits++;
        end
        check({tag, " valid count"}, hits, 0);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        qei_position = 32'd1234;
        repeat (3) @(negedge clock);
        check_outputs("in_reset", 0, 0, 0);
        check("in_reset valid", int'(valid), 0);

        reset = 1'b0;
        expect_quiet("idle", 100);
        check_outputs("idle", 0, 0, 0);

        // Priming tick at cycle 8 is silent; first valid lands 17 cycles after enable.
        qei_position = 32'd100;
        enable       = 1'b1;
        expect_sample("hold", 17, 0, 0, 0);
        @(negedge clock);
        check("pulse width", int'(valid), 0);

        for (int i = 0; i < 5; i++) begin
            qei_position = 32'd105 + 32'(5 * i);
            expect_sample($sformatf("ramp%0d", i), (i == 0) ? 7 : 8, 5, avg_tab[i], 0);
        end

        qei_position = 32'hFFFF_FFFE;
        expect_sample("wrap_prep", 8, -127, -28, 0);
        qei_position = 32'h0000_0003;
        expect_sample("wrap_up", 8, 5, -28, 0);
        qei_position = 32'h0000_0002;
        expect_sample("neg_floor", 8, -1, -30, 0);
        qei_position = 32'hFFFF_FFFD;
        expect_sample("wrap_down", 8, -5, -32, 0);

        qei_position = 32'd39997;
        expect_sample("sat_pos", 8, 32767, 8191, 1);
        qei_position = 32'hFFFF_FFFD;
        expect_sample("sat_neg", 8, -32768, -2, 1);

        // Drop enable the cycle after the next tick: in-flight sample must vanish.
        qei_position = 32'd97;
        repeat (7) @(negedge clock);
        enable = 1'b0;
        expect_quiet("drop", 20);
        check_outputs("drop hold", -32768, -2, 1);

        enable = 1'b1;
        expect_quiet("reprime", 10);
        qei_position = 32'd96;
        expect_sample("fresh", 7, -1, -1, 0);

        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_outputs("async_reset", 0, 0, 0);
        check("async_reset valid", int'(valid), 0);
        @(negedge clock);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
